fa_trojan_monitor: RTL

Passive run-time monitor that sits beside a single-bit full adder and observes its inputs and outputs every enabled cycle. It compares the observed outputs against an internal golden model, counts consecutive occurrences of the known trigger pattern (a=1, b=1, cin=0), and raises a sticky alarm on any functional mismatch. It is the in-silicon detector for the Trojan'ed full adder: it observes the adder instead of driving it and needs no test access. It supports combinational or registered adders through a configurable alignment delay.

---
 rtl/fa_mon_pkg.sv | 29 ++
 rtl/fa_mon_delay.sv | 36 +++
 rtl/fa_trojan_monitor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fa_mon_pkg.sv
// Shared types, constants and the golden full-adder reference for the
// full-adder run-time monitor.
package fa_mon_pkg;

  localparam int unsigned RUN_W   = 4;
  localparam int unsigned FAULT_W = 5;

  typedef enum logic [1:0] {
    ST_MON     = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_ALARM   = 2'd2
  } mon_state_e;

  // Observed adder sample travelling through the alignment pipeline
  typedef struct packed {
    logic v;
    logic a;
    logic b;
    logic cin;
  } fa_sample_t;

  localparam logic [2:0] TRIG_VEC = 3'b110;

  // Returns {cout, sum} of an ideal full adder
  function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic cin);
    fa_golden = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/fa_mon_delay.sv
// LAT-stage shift register with synchronous reset; LAT=0 is a straight wire.
module fa_mon_delay #(
  parameter int unsigned LAT = 0,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (LAT == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_pipe
    localparam int unsigned PW = LAT * W;

    logic [PW-1:0] pipe_q;
    logic [PW-1:0] pipe_d;

    // New sample enters at the bottom, oldest leaves at the top
    always_comb begin
      pipe_d = PW'({pipe_q, din});
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign dout = pipe_q[PW-1 -: W];
  end

endmodule

// File: rtl/fa_trojan_monitor.sv
// Passive monitor beside a 1-bit full adder: golden compare, trigger-run
// counting, MON/SUSPECT/ALARM tracking and mismatch capture.
module fa_trojan_monitor
  import fa_mon_pkg::*;
#(
  parameter int unsigned TRIG_THRESH = 8,
  parameter int unsigned LAT         = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             sum,
  input  logic             cout,
  input  logic             clr_alarm,
  output logic [1:0]       state_o,
  output logic             alarm,
  output logic [3:0]       run_len,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [4:0]       fault_vec,
  output logic             fault_valid
);

  localparam logic [RUN_W-1:0] THRESH  = RUN_W'(TRIG_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fa_sample_t smp_in;
  fa_sample_t smp_d;

  mon_state_e         state_q, state_d;
  logic               alarm_q, alarm_d;
  logic [RUN_W-1:0]   run_len_q, run_len_d;
  logic [CNT_W-1:0]   mismatch_cnt_q, mismatch_cnt_d;
  logic [FAULT_W-1:0] fault_vec_q, fault_vec_d;
  logic               fault_valid_q, fault_valid_d;

  logic mismatch_c;
  logic trig_c;
  logic clear_c;

  assign smp_in = '{v: en, a: a, b: b, cin: cin};

  fa_mon_delay #(
    .LAT (LAT),
    .W   ($bits(fa_sample_t))
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  (smp_in),
    .dout (smp_d)
  );

  // Compare, run counter, FSM and capture next-state
  always_comb begin
    state_d        = state_q;
    run_len_d      = run_len_q;
    mismatch_cnt_d = mismatch_cnt_q;
    fault_vec_d    = fault_vec_q;
    fault_valid_d  = fault_valid_q;

    mismatch_c = smp_d.v && ({cout, sum} != fa_golden(smp_d.a, smp_d.b, smp_d.cin));
    trig_c     = smp_d.v && ({smp_d.a, smp_d.b, smp_d.cin} == TRIG_VEC);
    clear_c    = clr_alarm && (state_q != ST_MON);

    // A clear beats a coincident trigger sample
    if (clear_c) begin
      run_len_d = '0;
    end else if (smp_d.v) begin
      if (!trig_c) begin
        run_len_d = '0;
      end else if (run_len_q < THRESH) begin
        run_len_d = run_len_q + RUN_W'(1);
      end
    end

    case (state_q)
      ST_MON:               if (run_len_d == THRESH) state_d = ST_SUSPECT;
      ST_SUSPECT, ST_ALARM: if (clear_c) state_d = ST_MON;
      default:              state_d = ST_MON;
    endcase

    if (clear_c) begin
      fault_valid_d = 1'b0;
    end

    // A mismatch overrides any clear on the same edge
    if (mismatch_c) begin
      state_d       = ST_ALARM;
      fault_vec_d   = {smp_d.a, smp_d.b, smp_d.cin, cout, sum};
      fault_valid_d = 1'b1;
      if (mismatch_cnt_q != CNT_MAX) begin
        mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
      end
    end

    alarm_d = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_MON;
      alarm_q        <= 1'b0;
      run_len_q      <= '0;
      mismatch_cnt_q <= '0;
      fault_vec_q    <= '0;
      fault_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      alarm_q        <= alarm_d;
      run_len_q      <= run_len_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      fault_vec_q    <= fault_vec_d;
      fault_valid_q  <= fault_valid_d;
    end
  end

  assign state_o      = state_q;
  assign alarm        = alarm_q;
  assign run_len      = run_len_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign fault_vec    = fault_vec_q;
  assign fault_valid  = fault_valid_q;

endmodule
